level_game_controller: RTL and testbench
========================================

# level_game_controller

Parametrised successor of the single-level game controller. It registers pairwise collisions between the bird (channel 0) and up to `NUM_OBJ-1` drawable object channels, emitting at most one hit pulse per channel per frame. It also runs a multi-level game FSM covering start, play, level-clear pause, advance, win and lose. It sits between the object drawers/VGA mux and the score, level-loader and physics blocks.

## Interface
- `NUM_OBJ`, 6: number of drawing-request channels; channel 0 is the bird, channels 1..NUM_OBJ-1 are targets (borders, wood, pig, heart, number, ...); legal range 2..16.
- `NUM_LEVELS`, 3: number of levels; legal range 1..15.
- `CNT_W`, 4: width of the pig and bird counters.
- `CLEAR_FRAMES`, 30: number of frames spent in the level-clear pause; legal range 1..255.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse at the start of each frame.
- `start_game` in 1: one-cycle request to start or restart the game.
- `draw_req` in NUM_OBJ: drawing requests for the current pixel; bit 0 is the bird.
- `pigs_left` in CNT_W: number of live pigs in the current level.
- `birds_left` in CNT_W: number of unlaunched birds.
- `bird_in_flight` in 1: the bird is currently moving.
- `collision` out NUM_OBJ-1: registered per-pixel collision; bit k-1 is bird ∧ channel k.
- `any_collision` out 1: OR of `collision`.
- `hit_pulse` out NUM_OBJ-1: one-cycle pulse per channel, at most once per frame.
- `SingleHitPulse` out 1: at most one pulse per frame for any channel.
- `level_load` out 1: one-cycle pulse commanding the loader to build `current_level`.
- `current_level` out LVL_W: current level index, 0-based.
- `game_over` out 1: level held high while in LOST.
- `game_won` out 1: level held high while in WON.
- `playing` out 1: high while in PLAY.

## Operation
- Collision stage, every cycle: `collision[k-1] <= draw_req[0] & draw_req[k]`. This stage is independent of FSM state.
- Frame flags: one `flag[k]` per channel plus a global flag. `startOfFrame` clears a flag. `collision` high with the flag clear sets the flag and fires the pulse. If the clear and the set happen in the same cycle, the set wins and the pulse fires.
- FSM states, encoded in the package: IDLE, LOAD, PLAY, CLEAR, WON, LOST.
- IDLE → LOAD on `start_game`, with `current_level` set to 0.
- LOAD: assert `level_load` for exactly one cycle, set the `armed` bit to 0, then go to PLAY on the next cycle.
- PLAY, on `startOfFrame`:
  - If `armed` is 0, set `armed` to 1 and do nothing else. The first frame after a load ignores the counters while the loader populates them.
  - Otherwise, if `pigs_left` is 0, go to CLEAR and zero the frame counter. Pig clear has priority over loss.
  - Otherwise, if `birds_left` is 0, `bird_in_flight` is low and `pigs_left` is nonzero, go to LOST.
- CLEAR: increment the frame counter on each `startOfFrame`. When the counter reaches `CLEAR_FRAMES`:
  - If `current_level` equals `NUM_LEVELS-1`, go to WON.
  - Otherwise increment `current_level` and go to LOAD.
- WON or LOST go to LOAD on `start_game`, with `current_level` set to 0.
- `start_game` in PLAY or CLEAR restarts the game: go to LOAD with level 0. In LOAD, `start_game` is ignored.
- `current_level` never exceeds `NUM_LEVELS-1`, so there is no wrap-around.
- `LVL_W` = max(1, $clog2(NUM_LEVELS)).
- The counter width is 8 bits.

## Timing
- `reset` takes effect on a clock edge.
- Reset values:
  - State is IDLE.
  - All flags, `collision`, `hit_pulse`, `SingleHitPulse`, `level_load`, `current_level`, `game_over`, `game_won`, `playing`, `armed` and the frame counter are 0.
- Reset asserted mid-level or mid-CLEAR aborts immediately to these values; no `level_load` pulse is issued.
- `draw_req` → `collision` latency is 1 cycle.
- `collision` → `hit_pulse`/`SingleHitPulse` latency is 1 cycle, so draw → pulse is 2 cycles.
- `start_game` → `level_load` latency is 1 cycle, because LOAD is entered on that edge.
- `game_over`, `game_won` and `playing` are registered decodes of the state, valid in the same cycle as the state.

## Structure
- Package `game_pkg` holds:
  - The `game_state_t` enum.
  - The bird channel index constant (0).
  - The `LVL_W` helper function.
- Sub-module `frame_hit_pulse`: a single-channel frame semaphore with inputs `clk`, `reset`, `startOfFrame`, `hit` and output `pulse`. It is instantiated NUM_OBJ-1 times in a generate loop, plus once for `SingleHitPulse` with `hit`=`any_collision`.

## Test plan
- Use NUM_OBJ=6. Drive `draw_req`=6'b000101 for 3 cycles in one frame → `collision`=5'b00010 from cycle 1; `hit_pulse[1]` for exactly one cycle at cycle 2; `SingleHitPulse` once. Drive the same pattern in the next frame → pulses again.
- Raise `startOfFrame` in the same cycle as the first `collision` → the pulse fires and the flag stays set; a later hit in the same frame → no pulse.
- Use NUM_LEVELS=3 and CLEAR_FRAMES=2. Send `start_game`, then hold `pigs_left`=0 from the start:
  - Armed frame: no transition.
  - Next frame: CLEAR.
  - After 2 frames: `current_level`=1 with a `level_load` pulse.
  - Repeat until level 2 clears → `game_won`=1 and `current_level` stays 2.
- In PLAY, hold `pigs_left`=3, `birds_left`=0 and `bird_in_flight`=1 → still PLAY. Drop `bird_in_flight` → `game_over`=1 at the next frame. Send `start_game` → LOAD, level 0.
- `pigs_left`=0 and `birds_left`=0 with `bird_in_flight`=0 on the same frame → CLEAR, not LOST.
- Assert `reset` for 1 cycle during CLEAR at level 1 → all outputs are 0 and the state is IDLE on the next cycle; no `level_load` pulse.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, bird channel index and level-width helper
package game_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CLEAR, WON, LOST} game_state_t;
  localparam int BIRD = 0;
  function automatic int lvl_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/frame_hit_pulse.sv
// frame_hit_pulse: one pulse per frame for a hit channel
//   clk, reset       : clock, synchronous active-high reset
//   startOfFrame     : clears the per-frame flag
//   hit              : registered collision for this channel
//   pulse            : one-cycle pulse on the first hit of a frame
module frame_hit_pulse (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic hit,
  output logic pulse
);
  logic r_flag;
  logic r_pulse;
  // a hit coinciding with the frame clear still fires and re-arms the flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= hit & (~r_flag | startOfFrame);
      r_flag  <= hit | (r_flag & ~startOfFrame);
    end
  end
  assign pulse = r_pulse;
endmodule

// File: rtl/level_game_controller.sv
// level_game_controller: bird collision pulses and multi-level game FSM
//   clk, reset                 : clock, synchronous active-high reset
//   startOfFrame, start_game   : frame pulse, start/restart request
//   draw_req                   : per-channel draw requests, bit 0 is the bird
//   pigs_left, birds_left      : level counters from the score/physics blocks
//   bird_in_flight             : bird currently moving
//   collision, any_collision   : registered bird-vs-channel overlap
//   hit_pulse, SingleHitPulse  : first hit per frame, per channel and global
//   level_load, current_level  : loader command and 0-based level index
//   game_over, game_won, playing : registered state decodes
module level_game_controller
  import game_pkg::*;
#(
  parameter  int NUM_OBJ      = 6,
  parameter  int NUM_LEVELS   = 3,
  parameter  int CNT_W        = 4,
  parameter  int CLEAR_FRAMES = 30,
  localparam int LVL_W        = lvl_w(NUM_LEVELS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic [NUM_OBJ-1:0] draw_req,
  input  logic [CNT_W-1:0]   pigs_left,
  input  logic [CNT_W-1:0]   birds_left,
  input  logic               bird_in_flight,
  output logic [NUM_OBJ-2:0] collision,
  output logic               any_collision,
  output logic [NUM_OBJ-2:0] hit_pulse,
  output logic               SingleHitPulse,
  output logic               level_load,
  output logic [LVL_W-1:0]   current_level,
  output logic               game_over,
  output logic               game_won,
  output logic               playing
);
  logic [NUM_OBJ-2:0] r_collision;
  game_state_t        r_state, w_next;
  logic               r_armed, r_load, r_over, r_won, r_play;
  logic [7:0]         r_cnt;
  logic [LVL_W-1:0]   r_level;
  logic               w_done, w_last;

  always_ff @(posedge clk) begin
    if (reset) r_collision <= '0;
    else       r_collision <= draw_req[NUM_OBJ-1:1] & {(NUM_OBJ-1){draw_req[BIRD]}};
  end

  assign collision     = r_collision;
  assign any_collision = |r_collision;

  for (genvar k = 1; k < NUM_OBJ; k++) begin : g_hit
    frame_hit_pulse u_hit (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .hit(r_collision[k-1]), .pulse(hit_pulse[k-1])
    );
  end

  frame_hit_pulse u_single (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .hit(any_collision), .pulse(SingleHitPulse)
  );

  assign w_done = (r_cnt + 8'd1) == 8'(CLEAR_FRAMES);
  assign w_last = r_level == LVL_W'(NUM_LEVELS - 1);

  // the first frame after a load is skipped (armed) while the loader fills the counters
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, WON, LOST: w_next = start_game ? LOAD : r_state;
      LOAD:            w_next = PLAY;
      PLAY: begin
        if (start_game) w_next = LOAD;
        else if (startOfFrame && r_armed) begin
          if (pigs_left == '0) w_next = CLEAR;
          else if (birds_left == '0 && !bird_in_flight) w_next = LOST;
        end
      end
      CLEAR: begin
        if (start_game) w_next = LOAD;
        else if (startOfFrame && w_done) w_next = w_last ? WON : LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_level <= '0;
      r_load  <= 1'b0;
      r_play  <= 1'b0;
      r_won   <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_load  <= w_next == LOAD;
      r_play  <= w_next == PLAY;
      r_won   <= w_next == WON;
      r_over  <= w_next == LOST;
      // only a natural CLEAR->LOAD advances the level; every other entry restarts at 0
      if (w_next == LOAD) r_level <= (r_state == CLEAR && !start_game) ? r_level + 1'b1 : '0;
      if (r_state == LOAD) r_armed <= 1'b0;
      else if (r_state == PLAY && startOfFrame) r_armed <= 1'b1;
      r_cnt <= (r_state == CLEAR) ? r_cnt + 8'(startOfFrame) : '0;
    end
  end

  assign level_load    = r_load;
  assign current_level = r_level;
  assign game_over     = r_over;
  assign game_won      = r_won;
  assign playing       = r_play;
endmodule

// File: tb/tb_level_game_controller.sv
// tb_level_game_controller: scoreboard bench for collision pulses and the level FSM
module tb_level_game_controller;
  logic       clk = 1'b0;
  logic       reset, startOfFrame, start_game, bird_in_flight;
  logic [5:0] draw_req;
  logic [3:0] pigs_left, birds_left;
  logic [4:0] collision, hit_pulse;
  logic       any_collision, SingleHitPulse, level_load, game_over, game_won, playing;
  logic [1:0] current_level;
  int         errors = 0;
  int         checks = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  level_game_controller #(.NUM_OBJ(6), .NUM_LEVELS(3), .CNT_W(4), .CLEAR_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_game(start_game),
    .draw_req(draw_req), .pigs_left(pigs_left), .birds_left(birds_left),
    .bird_in_flight(bird_in_flight), .collision(collision), .any_collision(any_collision),
    .hit_pulse(hit_pulse), .SingleHitPulse(SingleHitPulse), .level_load(level_load),
    .current_level(current_level), .game_over(game_over), .game_won(game_won),
    .playing(playing)
  );

  function automatic logic [17:0] ex(input logic [4:0] col, input logic [4:0] hp,
                                     input logic s, input logic load, input logic [1:0] lvl,
                                     input logic play, input logic won, input logic over);
    return {col, hp, s, |col, load, lvl, play, won, over};
  endfunction

  function automatic logic [17:0] obs();
    return {collision, hit_pulse, SingleHitPulse, any_collision, level_load,
            current_level, playing, game_won, game_over};
  endfunction

  task automatic drive(input logic rst, input logic sof, input logic st, input logic [5:0] d,
                       input logic [3:0] p, input logic [3:0] b, input logic f,
                       input logic [17:0] e);
    reset = rst; startOfFrame = sof; start_game = st; draw_req = d;
    pigs_left = p; birds_left = b; bird_in_flight = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'h05, 4'd0, 4'd0, 1'b0, ex(5'h0, 5'h0, 0, 0, 2'd0, 0, 0, 0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_collision();
    logic [5:0]  d[16]  = '{6'h00, 6'h05, 6'h05, 6'h05, 6'h00, 6'h00, 6'h05, 6'h00,
                            6'h00, 6'h09, 6'h00, 6'h00, 6'h09, 6'h00, 6'h33, 6'h00};
    logic [4:0]  ec[16] = '{5'h00, 5'h02, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02, 5'h00,
                            5'h00, 5'h04, 5'h00, 5'h00, 5'h04, 5'h00, 5'h19, 5'h00};
    logic [4:0]  eh[16] = '{5'h00, 5'h00, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02,
                            5'h00, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h19};
    string sof = "s.....s...s.....";
    string sgl = "..1....1..1.....";
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, sof[i] == "s", 1'b0, d[i], 4'd0, 4'd0, 1'b0,
            ex(ec[i], eh[i], sgl[i] == "1", 0, 2'd0, 0, 0, 0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL collision[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_levels_to_win();
    string seq  = "S.ssss.ssss.sssss.";
    string load = "1....1....1.......";
    string lvl  = "000001111122222222";
    string play = ".11...11...11.....";
    string won  = "...............111";
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, seq[i] == "s", seq[i] == "S", 6'h00, 4'd0, 4'd3, 1'b0,
            ex(5'h0, 5'h0, 0, load[i] == "1", 2'(lvl[i] - "0"), play[i] == "1", won[i] == "1", 0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL win[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_lose_and_restart();
    string seq  = "S.sss.S.";
    string fly  = "11110000";
    string load = "1.....1.";
    string play = ".111...1";
    string over = "....11..";
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, seq[i] == "s", seq[i] == "S", 6'h00, 4'd3, 4'd0, fly[i] == "1",
            ex(5'h0, 5'h0, 0, load[i] == "1", 2'd0, play[i] == "1", 0, over[i] == "1"));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lose[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_clear_priority();
    string seq  = "ssSSS.";
    string load = "..1.1.";
    string play = "1..1.1";
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, seq[i] == "s", seq[i] == "S", 6'h00, 4'd0, 4'd0, 1'b0,
            ex(5'h0, 5'h0, 0, load[i] == "1", 2'd0, play[i] == "1", 0, 0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL priority[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    string seq  = "ssss.ssRs.";
    string load = "...1......";
    string lvl  = "0001111000";
    string play = "1...11....";
    logic [17:0] e;
    logic [17:0] got;
    for (int i = 0; i < 10; i++) begin
      drive(seq[i] == "R", seq[i] == "s" || seq[i] == "R", 1'b0,
            (seq[i] == "R") ? 6'h05 : 6'h00, 4'd0, 4'd3, 1'b0,
            ex(5'h0, 5'h0, 0, load[i] == "1", 2'(lvl[i] - "0"), play[i] == "1", 0, 0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_clear[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_levels_to_win();
    test_lose_and_restart();
    test_clear_priority();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
